fp32_mul_arbiter: RTL and testbench
===================================

// Module: fp32_mul_arbiter
// PURPOSE
// - Shares one combinational Fp32_Multiplier among NUM_REQ requesters (e.g. systolic-array edge loaders, scaling units).
// - Round-robin arbitration, 2-stage pipeline (operand reg -> multiply -> result reg), valid/ready on both sides.
// - Sustains 1 multiply/cycle; response tagged with requester ID.
// PARAMETERS
// - NUM_REQ  4                       number of requesters, 1..16
// - ID_W     max(1,$clog2(NUM_REQ))  width of rsp_id_o, derived localparam
// PORTS
// - clk_i        in   1           clock, all logic on rising edge
// - rst_i        in   1           synchronous, active-high reset
// - req_valid_i  in   NUM_REQ     per-requester operand valid
// - req_ready_o  out  NUM_REQ     per-requester accept, at most one bit set (one-hot grant)
// - req_a_i      in   32*NUM_REQ  operand A of requester k at [32k+31:32k], IEEE-754 fp32
// - req_b_i      in   32*NUM_REQ  operand B of requester k, same packing
// - rsp_valid_o  out  1           result valid
// - rsp_ready_i  in   1           consumer accepts result
// - rsp_res_o    out  32          A*B from Fp32_Multiplier (no denormals, truncating)
// - rsp_id_o     out  ID_W        index of requester that issued the operation
// - stat_mul_cnt_o    out 32      completed responses (see CONFIGURATION)
// - stat_stall_cnt_o  out 32      backpressure cycles (see CONFIGURATION)
// BEHAVIOUR
// - Regs: S1 {s1_vld, a, b, id}, S2 {s2_vld, res, id}, rr_ptr (ID_W). Reset: s1_vld=s2_vld=0, rr_ptr=0,
//   data regs 0, counters 0 -> rsp_valid_o=0, rsp_res_o=0, rsp_id_o=0, req_ready_o=0 during and 1 cycle after? no: req_ready_o combinational, 0 while rst_i=1.
// - s2_adv = !s2_vld | rsp_ready_i; s1_adv = s1_vld & s2_adv; s1_free = !s1_vld | s1_adv.
// - Arbitration (comb): search req_valid_i starting at index rr_ptr, ascending, wrap NUM_REQ-1 -> 0; first hit k wins.
//   req_ready_o[k]=1 only if s1_free; all others 0. req_ready_o never depends on rsp path beyond s1_free.
// - Accept (req_valid_i[k] & req_ready_o[k]): S1 <= {1, A_k, B_k, k}; rr_ptr <= (k+1) mod NUM_REQ. No accept: rr_ptr holds.
// - S1 not refilled and s1_adv: s1_vld <= 0. S1 held (s1_vld & !s2_adv): contents stable.
// - s1_adv: S2 <= {1, mul(S1.a,S1.b), S1.id}; else if rsp_ready_i: s2_vld <= 0; else S2 stable.
// - Outputs driven from S2 regs only; rsp_valid_o/rsp_res_o/rsp_id_o stable while valid & !ready.
// - Latency: accept in cycle N -> rsp_valid_o in cycle N+2 with no backpressure. Throughput 1/cycle.
// - Ordering: responses leave in acceptance order; no drop, no duplicate.
// - Fairness: requester continuously valid waits at most NUM_REQ-1 grants.
// - Simultaneous: S2 drain and S1->S2 move and new accept in same cycle all legal (full throughput).
// - Full: s1_vld & s2_vld & !rsp_ready_i -> req_ready_o=0.
// - req_valid_i may drop without handshake; operands sampled only on accept.
// - Reset mid-operation: in-flight S1/S2 contents discarded, no response emitted, rr_ptr back to 0.
// - NUM_REQ=1: rr_ptr constant 0, rsp_id_o=0.
// CONFIGURATION
// - Macro FP32_MUL_ARB_STATS_EN.
// - Defined: stat_mul_cnt_o += 1 on each rsp_valid_o & rsp_ready_i; stat_stall_cnt_o += 1 each cycle
//   rsp_valid_o & !rsp_ready_i. Both 32-bit, wrap 0xFFFFFFFF -> 0, cleared by rst_i only.
// - Undefined: both ports tied to 32'h0, no counter flops; all other behaviour identical.
// TESTING
// - Single: req0 A=0x40000000 B=0x40400000, rsp_ready_i=1 -> cycle N+2 rsp_res_o=0x40C00000, rsp_id_o=0, 1-cycle valid.
// - RR: all 4 valid continuously, rsp_ready_i=1 -> grant order 0,1,2,3,0,...; 1 rsp/cycle; ids match grant order.
// - Backpressure: req2 A=0x3FC00000 B=0xC0000000, stream 3 ops, rsp_ready_i=0 5 cycles -> rsp holds 0xC0400000 id 2,
//   req_ready_o=0 after S1 fills, release -> 3 results in order, none lost.
// - Wrap/skip: rr_ptr=3, only req1 valid -> req1 granted, rr_ptr=2 afterwards.
// - Reset mid-op: assert rst_i with S1,S2 full -> next cycle rsp_valid_o=0, rr_ptr=0, no stale response after release.
// - Stats (FP32_MUL_ARB_STATS_EN): 10 responses with 3 stall cycles -> stat_mul_cnt_o=10, stat_stall_cnt_o=3; undefined -> both 0.

Source files
------------

// File: rtl/fp32_mul_arbiter.sv
// Round-robin arbiter sharing one truncating fp32 multiplier through a 2-stage valid/ready pipeline.
// Optional macro FP32_MUL_ARB_STATS_EN enables the response and stall counters.
module fp32_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  input  logic [32*NUM_REQ-1:0]   req_a_i,
  input  logic [32*NUM_REQ-1:0]   req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [31:0]             rsp_res_o,
  output logic [ID_W-1:0]         rsp_id_o,
  output logic [31:0]             stat_mul_cnt_o,
  output logic [31:0]             stat_stall_cnt_o
);

  localparam int unsigned DW = 32;

  logic            s1_vld, s2_vld;
  logic [DW-1:0]   s1_a, s1_b, s2_res;
  logic [ID_W-1:0] s1_id, s2_id, rr_ptr;
  logic            s2_adv, s1_adv, s1_free;
  logic            hit, accept;
  logic [ID_W-1:0] win;
  logic [DW-1:0]   mul_res;

  function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] base, input int unsigned off);
    return ID_W'((32'(base) + off) % NUM_REQ);
  endfunction

  assign s2_adv  = !s2_vld || rsp_ready_i;
  assign s1_adv  = s1_vld && s2_adv;
  assign s1_free = !s1_vld || s1_adv;

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_valid_i[wrap_inc(rr_ptr, i)]) begin
        hit = 1'b1;
        win = wrap_inc(rr_ptr, i);
      end
    end
  end

  assign accept      = hit && s1_free && !rst_i;
  assign req_ready_o = accept ? (NUM_REQ'(1) << win) : '0;

  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic [24:0] prod_hi;
  logic [9:0]  esum;
  logic [22:0] mant;
  logic        sign, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  // Multiplier: denormal inputs and underflow flush to zero, mantissa truncated.
  always_comb begin
    ea      = s1_a[30:23];
    eb      = s1_b[30:23];
    fa      = s1_a[22:0];
    fb      = s1_b[22:0];
    sign    = s1_a[31] ^ s1_b[31];
    prod_hi = 25'((48'({1'b1, fa}) * 48'({1'b1, fb})) >> 23);
    esum    = 10'(ea) + 10'(eb) + 10'(prod_hi[24]);
    mant    = prod_hi[24] ? prod_hi[23:1] : prod_hi[22:0];
    a_nan   = (ea == 8'hFF) && (fa != '0);
    b_nan   = (eb == 8'hFF) && (fb != '0);
    a_inf   = (ea == 8'hFF) && (fa == '0);
    b_inf   = (eb == 8'hFF) && (fb == '0);
    a_zero  = (ea == 8'h00);
    b_zero  = (eb == 8'h00);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      mul_res = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      mul_res = {sign, 8'hFF, 23'h0};
    end else if (a_zero || b_zero) begin
      mul_res = {sign, 31'h0};
    end else if (esum >= 10'd382) begin
      mul_res = {sign, 8'hFF, 23'h0};
    end else if (esum <= 10'd127) begin
      mul_res = {sign, 31'h0};
    end else begin
      mul_res = {sign, 8'(esum - 10'd127), mant};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_id  <= '0;
      s2_vld <= 1'b0;
      s2_res <= '0;
      s2_id  <= '0;
      rr_ptr <= '0;
    end else begin
      if (accept) begin
        s1_vld <= 1'b1;
        s1_a   <= req_a_i[DW*32'(win) +: DW];
        s1_b   <= req_b_i[DW*32'(win) +: DW];
        s1_id  <= win;
        rr_ptr <= wrap_inc(win, 1);
      end else if (s1_adv) begin
        s1_vld <= 1'b0;
      end
      if (s1_adv) begin
        s2_vld <= 1'b1;
        s2_res <= mul_res;
        s2_id  <= s1_id;
      end else if (rsp_ready_i) begin
        s2_vld <= 1'b0;
      end
    end
  end

  assign rsp_valid_o = s2_vld;
  assign rsp_res_o   = s2_res;
  assign rsp_id_o    = s2_id;

`ifdef FP32_MUL_ARB_STATS_EN
  logic [31:0] mul_cnt, stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mul_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (s2_vld && rsp_ready_i) mul_cnt <= mul_cnt + 32'd1;
      if (s2_vld && !rsp_ready_i) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stat_mul_cnt_o   = mul_cnt;
  assign stat_stall_cnt_o = stall_cnt;
`else
  assign stat_mul_cnt_o   = '0;
  assign stat_stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
// Self-checking bench for fp32_mul_arbiter: directed vector table, multi-cycle sequences and a
// randomized phase scored against a real-arithmetic reference model.
module tb_fp32_mul_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid, req_ready;
  logic [32*NUM_REQ-1:0] req_a, req_b;
  logic                  rsp_valid, rsp_ready;
  logic [31:0]           rsp_res;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           stat_mul, stat_stall;

  always #5 clk = ~clk;

  fp32_mul_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a_i(req_a), .req_b_i(req_b),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_res_o(rsp_res), .rsp_id_o(rsp_id),
    .stat_mul_cnt_o(stat_mul), .stat_stall_cnt_o(stat_stall)
  );

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] res; } vec_t;
  typedef struct { logic [ID_W-1:0] id; logic [31:0] res; } sb_t;

  sb_t             sbq[$];
  int              exp_grants[$];
  logic [31:0]     exp_of [NUM_REQ];
  vec_t            vecs [14];
  int              total = 0, bad = 0;
  int              n_acc = 0, n_rsp = 0, n_stall = 0, last_grant = -1;
  logic            hold_prev = 1'b0;
  logic [31:0]     prev_res = '0;
  logic [ID_W-1:0] prev_id = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Reference: exact product in double precision, then truncate to fp32 (normal range only).
  function automatic real to_real(input logic [31:0] x);
    return $bitstoreal({x[31], 11'(32'(x[30:23]) + 32'd896), x[22:0], 29'b0});
  endfunction

  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    d = $realtobits(to_real(a) * to_real(b));
    return {d[63], 8'(32'(d[62:52]) - 32'd896), d[51:29]};
  endfunction

  function automatic logic [31:0] rand_normal();
    return {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)};
  endfunction

  task automatic set_op(input int k, input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    req_a[32*k +: 32] = a;
    req_b[32*k +: 32] = b;
    exp_of[k] = e;
  endtask

  task automatic rand_ops();
    logic [31:0] a, b;
    for (int k = 0; k < NUM_REQ; k++) begin
      a = rand_normal();
      b = rand_normal();
      set_op(k, a, b, ref_mul(a, b));
    end
  endtask

  // Observe one cycle mid-period, score handshakes, then advance past the next rising edge.
  task automatic cyc();
    sb_t e;
    logic [NUM_REQ-1:0] acc;
    #1;
    acc = req_valid & req_ready;
    if (rst) begin
      chk("ready_in_reset", 32'(req_ready), 32'h0);
    end else begin
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'h1);
      chk("ready_only_valid", 32'(req_ready & ~req_valid), 32'h0);
      chk("grant_when_free", 32'(req_ready != '0),
          32'((req_valid != '0) && (sbq.size() < 2 || rsp_ready)));
      if (hold_prev) begin
        chk("hold_valid", 32'(rsp_valid), 32'h1);
        chk("hold_res", rsp_res, prev_res);
        chk("hold_id", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && rsp_ready) begin
        n_rsp++;
        chk("rsp_has_pending", 32'(sbq.size() != 0), 32'h1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("rsp_res", rsp_res, e.res);
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
        end
      end
      if (rsp_valid && !rsp_ready) n_stall++;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (acc[k]) begin
          sbq.push_back('{id: ID_W'(k), res: exp_of[k]});
          n_acc++;
          last_grant = k;
          if (exp_grants.size() != 0) chk("grant_order", 32'(k), 32'(exp_grants.pop_front()));
        end
      end
    end
    hold_prev = rsp_valid && !rsp_ready && !rst;
    prev_res  = rsp_res;
    prev_id   = rsp_id;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 20 && sbq.size() != 0; i++) cyc();
    chk("drain_empty", 32'(sbq.size()), 32'h0);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    cyc();
    cyc();
    sbq.delete();
    exp_grants.delete();
    hold_prev = 1'b0;
    rst       = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, r0, s0;
    vecs[0]  = '{32'h4000_0000, 32'h4040_0000, 32'h40C0_0000};
    vecs[1]  = '{32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000};
    vecs[2]  = '{32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000};
    vecs[3]  = '{32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002};
    vecs[4]  = '{32'h3FFF_FFFF, 32'h3FFF_FFFF, 32'h407F_FFFE};
    vecs[5]  = '{32'h0000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[6]  = '{32'h8000_0000, 32'h3F80_0000, 32'h8000_0000};
    vecs[7]  = '{32'h0040_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8]  = '{32'h7F80_0000, 32'hC000_0000, 32'hFF80_0000};
    vecs[9]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000};
    vecs[10] = '{32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000};
    vecs[11] = '{32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000};
    vecs[12] = '{32'h0080_0000, 32'h3F00_0000, 32'h0000_0000};
    vecs[13] = '{32'h3F80_0000, 32'hBF80_0000, 32'hBF80_0000};

    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
    for (int k = 0; k < NUM_REQ; k++) exp_of[k] = '0;
    @(posedge clk);
    #1;

    // Reset state
    do_reset();
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_res", rsp_res, 32'h0);
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_stat_mul", stat_mul, 32'h0);
    chk("reset_stat_stall", stat_stall, 32'h0);

    // Single op latency: accept in N, valid only in N+2
    set_op(0, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    cyc();
    chk("single_grant", 32'(last_grant), 32'h0);
    req_valid = '0;
    chk("single_n1_valid", 32'(rsp_valid), 32'h0);
    cyc();
    chk("single_n2_valid", 32'(rsp_valid), 32'h1);
    chk("single_n2_res", rsp_res, 32'h40C0_0000);
    chk("single_n2_id", 32'(rsp_id), 32'h0);
    cyc();
    chk("single_n3_valid", 32'(rsp_valid), 32'h0);

    // Directed vector table through requester 0
    r0 = n_rsp;
    for (int v = 0; v < 14; v++) begin
      set_op(0, vecs[v].a, vecs[v].b, vecs[v].res);
      req_valid = 4'b0001;
      cyc();
      req_valid = '0;
      cyc();
      cyc();
    end
    drain();
    chk("vec_rsp_count", 32'(n_rsp - r0), 32'd14);

    // Backpressure: hold result, stop granting when full, release in order
    n0 = n_acc; r0 = n_rsp;
    rsp_ready = 1'b0;
    req_valid = 4'b0100;
    set_op(2, 32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000);
    cyc();
    set_op(2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000);
    cyc();
    set_op(2, 32'h3F80_0000, 32'h4080_0000, 32'h4080_0000);
    cyc(); cyc(); cyc();
    chk("bp_accepts_stalled", 32'(n_acc - n0), 32'd2);
    chk("bp_full_ready", 32'(req_ready), 32'h0);
    chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
    chk("bp_hold_res", rsp_res, 32'hC040_0000);
    chk("bp_hold_id", 32'(rsp_id), 32'd2);
    rsp_ready = 1'b1;
    cyc();
    chk("bp_accept_on_release", 32'(n_acc - n0), 32'd3);
    drain();
    chk("bp_rsp_count", 32'(n_rsp - r0), 32'd3);

    // Reset with both stages full: everything discarded, pointer back to 0
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    rand_ops();
    cyc(); cyc(); cyc();
    chk("rst_pipe_full", 32'(sbq.size()), 32'd2);
    rst = 1'b1;
    cyc();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_res", rsp_res, 32'h0);
    sbq.delete();
    hold_prev = 1'b0;
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    cyc(); cyc(); cyc();
    chk("rst_no_stale", 32'(rsp_valid), 32'h0);

    // Round robin from pointer 0 with everyone valid, full throughput
    r0 = n_rsp;
    req_valid = 4'b1111;
    for (int i = 0; i < 8; i++) exp_grants.push_back(i % 4);
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      cyc();
    end
    chk("rr_grants_done", 32'(exp_grants.size()), 32'h0);
    chk("rr_throughput", 32'(n_rsp - r0), 32'd6);

    // Wrap/skip: pointer at 3, only req1 valid, then pointer must sit at 2
    rand_ops();
    req_valid = 4'b0100; exp_grants.push_back(2); cyc();
    req_valid = 4'b0010; exp_grants.push_back(1); cyc();
    req_valid = 4'b1111; exp_grants.push_back(2); cyc();
    chk("wrap_grants_done", 32'(exp_grants.size()), 32'h0);
    drain();

    // Randomized traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      rand_ops();
      req_valid = 4'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    drain();

    // Statistics: 10 responses with 3 stall cycles
    do_reset();
    n0 = n_acc; s0 = n_stall;
    req_valid = 4'b0010;
    for (int c = 0; c < 40 && (n_acc - n0) < 10; c++) begin
      rand_ops();
      rsp_ready = !(c >= 4 && c <= 6);
      cyc();
    end
    drain();
    chk("stats_accepts", 32'(n_acc - n0), 32'd10);
    chk("stats_observed_stalls", 32'(n_stall - s0), 32'd3);
`ifdef FP32_MUL_ARB_STATS_EN
    chk("stat_mul_cnt", stat_mul, 32'd10);
    chk("stat_stall_cnt", stat_stall, 32'd3);
`else
    chk("stat_mul_cnt", stat_mul, 32'd0);
    chk("stat_stall_cnt", stat_stall, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
